// File: rtl/mixer_nch.sv
// mixer_nch: N-channel weighted sample mixer.
// Samples and gains are written into staging registers at any time. A start
// request copies the staging set into working registers. The block then
// accumulates sample*gain one channel per cycle, scales the sum down by
// LEVEL_W bits and clips it to OUT_W bits.
//
// Ports:
//   i_clock     - sole clock, rising edge
//   i_reset_n   - asynchronous active-low reset
//   i_sample    - sample data for a staging load
//   i_load      - write i_sample into staging channel i_load_ch
//   i_load_ch   - staging sample channel index (out-of-range ignored)
//   i_level     - gain data for a staging gain write
//   i_level_we  - write i_level into staging channel i_level_ch
//   i_level_ch  - staging gain channel index (out-of-range ignored)
//   i_start     - request one mix pass (honoured only when idle)
//   o_busy      - mix pass in progress
//   o_valid     - one-cycle pulse when o_output/o_sat are updated
//   o_output    - registered, clipped mix result
//   o_sat       - last result was clipped
module mixer_nch #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned LEVEL_W  = 3,
  parameter int unsigned OUT_W    = 12,
  localparam int unsigned CH_W    = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_load,
  input  logic [CH_W-1:0]     i_load_ch,
  input  logic [LEVEL_W-1:0]  i_level,
  input  logic                i_level_we,
  input  logic [CH_W-1:0]     i_level_ch,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_valid,
  output logic [OUT_W-1:0]    o_output,
  output logic                o_sat
);

  // NUM_CH <= 2**CH_W, so the sum of NUM_CH full-scale products fits.
  localparam int unsigned ACC_W = SAMPLE_W + LEVEL_W + CH_W;
  // Compare width for clipping: at least one bit wider than OUT_W.
  localparam int unsigned EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, next_state;

  logic [SAMPLE_W-1:0] stage_sample [NUM_CH];
  logic [LEVEL_W-1:0]  stage_level  [NUM_CH];
  logic [SAMPLE_W-1:0] work_sample  [NUM_CH];
  logic [LEVEL_W-1:0]  work_level   [NUM_CH];
  logic [ACC_W-1:0]    acc;
  logic [CH_W-1:0]     idx;
  logic [ACC_W-1:0]    prod;
  logic [EXT_W-1:0]    result;
  logic [EXT_W-1:0]    out_max;

  always_comb begin
    prod    = ACC_W'(work_sample[idx]) * ACC_W'(work_level[idx]);
    result  = EXT_W'(acc >> LEVEL_W);
    out_max = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = ACCUM;
      ACCUM:   if (idx == LAST_CH) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy = (state != IDLE);
  end

  // Datapath
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        stage_sample[c] <= '0;
        stage_level[c]  <= '0;
        work_sample[c]  <= '0;
        work_level[c]   <= '0;
      end
      acc      <= '0;
      idx      <= '0;
      o_valid  <= 1'b0;
      o_output <= '0;
      o_sat    <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      // Index compare against every real channel; indices >= NUM_CH never match.
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (i_load && (i_load_ch == CH_W'(c)))
          stage_sample[c] <= i_sample;
        if (i_level_we && (i_level_ch == CH_W'(c)))
          stage_level[c] <= i_level;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            // Snapshot uses pre-edge staging, so a same-edge load lands only in staging.
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              work_sample[c] <= stage_sample[c];
              work_level[c]  <= stage_level[c];
            end
            acc <= '0;
            idx <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + prod;
          idx <= (idx == LAST_CH) ? '0 : idx + CH_W'(1);
        end
        DONE: begin
          o_valid <= 1'b1;
          if (result > out_max) begin
            o_output <= '1;
            o_sat    <= 1'b1;
          end else begin
            o_output <= result[OUT_W-1:0];
            o_sat    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mixer_nch.sv
// tb_mixer_nch: directed bench for mixer_nch.
// Three instances share every input: defaults (u_dut), OUT_W=8 (u_sat8) and
// NUM_CH=3 (u_ch3). All three use a 2-bit channel index.
module tb_mixer_nch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample;
  logic       load;
  logic [1:0] load_ch;
  logic [2:0] level;
  logic       level_we;
  logic [1:0] level_ch;
  logic       start;

  logic        busy, valid, sat;
  logic [11:0] out;
  logic        busy8, valid8, sat8;
  logic [7:0]  out8;
  logic        busy3, valid3, sat3;
  logic [11:0] out3;

  int checks   = 0;
  int failures = 0;
  int vcount;
  int vpos1;
  int vpos2;
  int valid_seen;

  always #5 clk = ~clk;

  mixer_nch u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_sample(sample), .i_load(load),
    .i_load_ch(load_ch), .i_level(level), .i_level_we(level_we),
    .i_level_ch(level_ch), .i_start(start), .o_busy(busy), .o_valid(valid),
    .o_output(out), .o_sat(sat)
  );

  mixer_nch #(.OUT_W(8)) u_sat8 (
    .i_clock(clk), .i_reset_n(rst_n), .i_sample(sample), .i_load(load),
    .i_load_ch(load_ch), .i_level(level), .i_level_we(level_we),
    .i_level_ch(level_ch), .i_start(start), .o_busy(busy8), .o_valid(valid8),
    .o_output(out8), .o_sat(sat8)
  );

  mixer_nch #(.NUM_CH(3)) u_ch3 (
    .i_clock(clk), .i_reset_n(rst_n), .i_sample(sample), .i_load(load),
    .i_load_ch(load_ch), .i_level(level), .i_level_we(level_we),
    .i_level_ch(level_ch), .i_start(start), .o_busy(busy3), .o_valid(valid3),
    .o_output(out3), .o_sat(sat3)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input int ch, input int s, input int g);
    load = 1'b1; load_ch = 2'(ch); sample = 8'(s);
    level_we = 1'b1; level_ch = 2'(ch); level = 3'(g);
    tick();
    load = 1'b0; level_we = 1'b0;
  endtask

  // Start edge plus five more edges; o_valid must appear only after the last.
  task automatic run_pass(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    valid_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i < 5 && valid) valid_seen++;
    end
    chk({tag, "_early_valid"}, valid_seen, 0);
    chk({tag, "_valid"}, int'(valid), 1);
  endtask

  initial begin
    rst_n = 1'b0; sample = '0; load = 1'b0; load_ch = '0; level = '0;
    level_we = 1'b0; level_ch = '0; start = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_sat", int'(sat), 0);
    #20 rst_n = 1'b1;
    tick();

    // Basic mix: 200*7+100*4+50*0+255*1 = 2055, >>3 = 256
    load_pair(0, 200, 7);
    load_pair(1, 100, 4);
    load_pair(2, 50, 0);
    load_pair(3, 255, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_busy_k", int'(busy), 1);
    vcount = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i <= 4) begin
        if (busy) vcount++;
        if (valid) vcount += 100;
      end
    end
    chk("basic_busy_cycles", vcount, 4);
    chk("basic_valid", int'(valid), 1);
    chk("basic_busy_end", int'(busy), 0);
    chk("basic_out", int'(out), 256);
    chk("basic_sat", int'(sat), 0);
    chk("basic8_out", int'(out8), 255);
    chk("basic8_sat", int'(sat8), 1);
    chk("basic3_out", int'(out3), 225);
    tick();
    chk("basic_valid_pulse", int'(valid), 0);
    chk("basic_hold", int'(out), 256);

    // Saturation: 4*255*7 = 7140, >>3 = 892; NUM_CH=3: 5355 >>3 = 669
    for (int c = 0; c < 4; c++) load_pair(c, 255, 7);
    run_pass("sat");
    chk("sat12_out", int'(out), 892);
    chk("sat12_sat", int'(sat), 0);
    chk("sat8_out", int'(out8), 255);
    chk("sat8_sat", int'(sat8), 1);
    chk("sat3_out", int'(out3), 669);

    // Snapshot: ch1=100 staged; load ch1=0 on start edge and mid-ACCUM.
    load_pair(1, 100, 7);
    start = 1'b1; load = 1'b1; load_ch = 2'd1; sample = 8'd0;
    tick();
    start = 1'b0; load = 1'b0;
    tick();
    load = 1'b1; load_ch = 2'd1; sample = 8'd0;
    tick();
    load = 1'b0;
    for (int i = 3; i <= 5; i++) tick();
    chk("snap_valid", int'(valid), 1);
    chk("snap_out", int'(out), 756);    // (255*3+100)*7 = 6055 >>3
    run_pass("snap2");
    chk("snap2_out", int'(out), 669);   // 255*3*7 = 5355 >>3

    // Start during busy: extra pulses at k+2 and k+5 ignored; k+6 accepted.
    start = 1'b1;
    tick();
    start = 1'b0;
    vcount = 0; vpos1 = -1; vpos2 = -1;
    for (int i = 1; i <= 11; i++) begin
      start = (i == 2 || i == 5 || i == 6);
      tick();
      if (valid) begin
        vcount++;
        if (vpos1 < 0) vpos1 = i;
        else vpos2 = i;
      end
    end
    start = 1'b0;
    chk("busy_start_count", vcount, 2);
    chk("busy_start_first", vpos1, 5);
    chk("busy_start_period", vpos2 - vpos1, 6);

    // Reset mid-pass
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_out", int'(out), 0);
    chk("mrst_sat", int'(sat), 0);
    chk("mrst_valid", int'(valid), 0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid || busy) vcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid || busy) vcount++;
    end
    chk("mrst_no_activity", vcount, 0);
    run_pass("post_rst");
    chk("post_rst_out", int'(out), 0);
    chk("post_rst_sat", int'(sat), 0);

    // Out-of-range index on NUM_CH=3; in range on the 4-channel instances.
    load_pair(3, 255, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    vcount = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 4 && valid3) vcount++;
    end
    chk("oor3_valid_at4", vcount, 1);
    chk("oor3_out", int'(out3), 0);
    chk("oor3_sat", int'(sat3), 0);
    chk("oor4_out", int'(out), 223);    // 255*7 = 1785 >>3
    chk("oor8_out", int'(out8), 223);
    chk("oor8_sat", int'(sat8), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mixer_nch.md
MIXER_NCH -- requirements
Module: mixer_nch

Interface
REQ-001 Parameter SAMPLE_W, default 8: unsigned sample width.
REQ-002 Parameter NUM_CH, default 4: channel count, 2..16.
REQ-003 Parameter LEVEL_W, default 3: unsigned per-channel gain width.
REQ-004 Parameter OUT_W, default 12: output width; CH_W = max(1, clog2(NUM_CH)).
REQ-005 The module SHALL have these ports:
- i_clock  in  1  sole clock, all state on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_sample  in  SAMPLE_W  sample data for a load.
- i_load  in  1  write i_sample into the staging register selected by i_load_ch.
- i_load_ch  in  CH_W  load channel index.
- i_level  in  LEVEL_W  gain value.
- i_level_we  in  1  write i_level into the staging gain selected by i_level_ch.
- i_level_ch  in  CH_W  gain channel index.
- i_start  in  1  request one mix pass.
- o_busy  out  1  mix pass in progress.
- o_valid  out  1  one-cycle pulse; o_output is updated.
- o_output  out  OUT_W  registered mix result.
- o_sat  out  1  last result was clipped; registered with o_output.

Function
REQ-006 The block SHALL hold NUM_CH staging sample/gain pairs and NUM_CH working pairs.
- Loads and gain writes touch only staging.
- The mix reads only working.
REQ-007 Loads SHALL be accepted in any state; an index >= NUM_CH SHALL be ignored.
- i_load and i_level_we SHALL act independently in the same cycle.
REQ-008 FSM states SHALL be IDLE, ACCUM and DONE; reset state is IDLE.
REQ-009 IDLE with i_start=1 at edge k SHALL:
- copy all staging pairs to working, using pre-edge staging values;
- clear the accumulator and set the channel index to 0;
- go to ACCUM.
REQ-010 ACCUM SHALL add working_sample[idx]*working_level[idx] to the accumulator, one channel per edge (k+1..k+NUM_CH), then go to DONE after channel NUM_CH-1.
REQ-011 The accumulator SHALL be SAMPLE_W+LEVEL_W+CH_W bits unsigned and SHALL never wrap.
REQ-012 DONE at edge k+NUM_CH+1 SHALL register the result, pulse o_valid high for exactly one cycle, and return to IDLE.
- result = accumulator >> LEVEL_W.
- If result > 2^OUT_W-1: o_output = 2^OUT_W-1 and o_sat=1; otherwise o_output = result and o_sat=0.
REQ-013 o_busy SHALL be 1 in ACCUM and DONE and 0 in IDLE.
REQ-014 i_start outside IDLE SHALL be ignored and SHALL NOT be queued.
- Minimum start-to-start period is NUM_CH+2 cycles.
REQ-015 A load to channel c on the same edge as an accepted start SHALL leave working[c] with the old value and staging[c] with the new value.
REQ-016 o_output and o_sat SHALL hold their values between o_valid pulses.

Reset
REQ-017 When i_reset_n=0, the block SHALL immediately, without waiting for a clock:
- clear all staging and working samples and gains, the accumulator, the index, o_output, o_sat, o_valid and o_busy to 0;
- set the FSM to IDLE.
REQ-018 A reset during ACCUM or DONE SHALL abort the pass with no o_valid pulse; the first accepted start after reset release SHALL mix all-zero data unless loads intervene.

Verification
REQ-019 The bench SHALL cover these scenarios (defaults unless noted):
- Basic mix: samples 200,100,50,255 with gains 7,4,0,1, then start. Required: o_valid on the 5th edge after the start edge; o_output=256 (2055>>3); o_sat=0; o_busy high 5 cycles.
- Saturation (OUT_W=8): all samples 255, all gains 7, start. Required: o_output=255, o_sat=1. The same stimulus with OUT_W=12 gives 892 and o_sat=0.
- Snapshot: ch1 sample=100 before start; load ch1=0 on the start edge and again mid-ACCUM. Required: this pass uses 100; the next pass uses 0.
- Start during busy: pulse i_start at edges k+2 and k+5. Required: exactly one o_valid; a start in the cycle after o_valid gives the next o_valid at period NUM_CH+2.
- Reset mid-pass: assert i_reset_n=0 asynchronously at k+2. Required: o_busy, o_output, o_sat all 0 immediately and no o_valid. After release, a start yields o_output=0.
- Out-of-range index (NUM_CH=3, CH_W=2): load ch3=255 with gain 7, start. Required: o_output unaffected (0 after reset).
